// File: rtl/rename_reg_file_if.sv
// Decoder/ROB-facing bundle of the rename register file: source reads,
// destination rename, multi-channel commit, flush and the global ready.
interface rename_reg_file_if #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int ROB_W   = 4,
  parameter int NCOMMIT = 1
);
  localparam int RIDX_W = $clog2(NREG);

  logic                      rdy;
  logic [RIDX_W-1:0]         rs1_index;
  logic [RIDX_W-1:0]         rs2_index;
  logic                      need_rs1;
  logic                      need_rs2;
  logic                      rd_valid;
  logic [RIDX_W-1:0]         rd_index;
  logic [ROB_W-1:0]          rd_tag;
  logic [XLEN-1:0]           rs1_value;
  logic [XLEN-1:0]           rs2_value;
  logic                      rs1_renamed;
  logic                      rs2_renamed;
  logic [ROB_W-1:0]          rs1_tag;
  logic [ROB_W-1:0]          rs2_tag;
  logic [NCOMMIT-1:0]        commit_valid;
  logic [NCOMMIT*RIDX_W-1:0] commit_index;
  logic [NCOMMIT*ROB_W-1:0]  commit_tag;
  logic [NCOMMIT*XLEN-1:0]   commit_value;
  logic                      flush;

  // Strobes (rd_valid, commit_valid, flush) are single-cycle qualifiers that
  // take effect on the clock edge where rdy is high; reads have no handshake
  // and are valid combinationally in the same cycle.
  modport master (
    output rdy, rs1_index, rs2_index, need_rs1, need_rs2,
    output rd_valid, rd_index, rd_tag,
    output commit_valid, commit_index, commit_tag, commit_value, flush,
    input  rs1_value, rs2_value, rs1_renamed, rs2_renamed, rs1_tag, rs2_tag
  );

  modport slave (
    input  rdy, rs1_index, rs2_index, need_rs1, need_rs2,
    input  rd_valid, rd_index, rd_tag,
    input  commit_valid, commit_index, commit_tag, commit_value, flush,
    output rs1_value, rs2_value, rs1_renamed, rs2_renamed, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB rename tags, tag-matched
// release, commit-to-read bypass, multi-channel commit, flush and hardwired x0.
module rename_reg_file #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int ROB_W   = 4,
  parameter int NCOMMIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  rename_reg_file_if.slave rf
);
  localparam int RIDX_W = $clog2(NREG);

  logic [XLEN-1:0]   val_q [NREG];
  logic [XLEN-1:0]   val_d [NREG];
  logic [NREG-1:0]   ren_q;
  logic [NREG-1:0]   ren_d;
  logic [ROB_W-1:0]  tag_q [NREG];
  logic [ROB_W-1:0]  tag_d [NREG];

  logic              c_valid [NCOMMIT];
  logic [RIDX_W-1:0] c_idx   [NCOMMIT];
  logic [ROB_W-1:0]  c_tag   [NCOMMIT];
  logic [XLEN-1:0]   c_val   [NCOMMIT];

  always_comb begin
    for (int k = 0; k < NCOMMIT; k++) begin
      c_valid[k] = rf.commit_valid[k];
      c_idx[k]   = rf.commit_index[k*RIDX_W +: RIDX_W];
      c_tag[k]   = rf.commit_tag[k*ROB_W +: ROB_W];
      c_val[k]   = rf.commit_value[k*XLEN +: XLEN];
    end
  end

  // Source reads: index 0 is rs1, index 1 is rs2.
  logic [RIDX_W-1:0] src_idx  [2];
  logic              src_need [2];
  logic [XLEN-1:0]   src_val  [2];
  logic              src_ren  [2];
  logic [ROB_W-1:0]  src_tag  [2];
  logic              src_hit  [2];

  always_comb begin
    src_idx[0]  = rf.rs1_index;
    src_idx[1]  = rf.rs2_index;
    src_need[0] = rf.need_rs1;
    src_need[1] = rf.need_rs2;
    for (int s = 0; s < 2; s++) begin
      src_val[s] = (src_idx[s] == '0) ? '0 : val_q[src_idx[s]];
      src_hit[s] = 1'b0;
      // Ascending scan so the youngest matching channel supplies the value.
      if (src_idx[s] != '0 && ren_q[src_idx[s]]) begin
        for (int k = 0; k < NCOMMIT; k++) begin
          if (c_valid[k] && c_idx[k] == src_idx[s] && c_tag[k] == tag_q[src_idx[s]]) begin
            src_val[s] = c_val[k];
            src_hit[s] = 1'b1;
          end
        end
      end
      src_ren[s] = src_need[s] && (src_idx[s] != '0) && ren_q[src_idx[s]] && !src_hit[s];
      src_tag[s] = src_ren[s] ? tag_q[src_idx[s]] : '0;
    end
  end

  assign rf.rs1_value   = src_val[0];
  assign rf.rs2_value   = src_val[1];
  assign rf.rs1_renamed = src_ren[0];
  assign rf.rs2_renamed = src_ren[1];
  assign rf.rs1_tag     = src_tag[0];
  assign rf.rs2_tag     = src_tag[1];

  // Next state, lowest to highest priority: commit release, issue, flush.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      val_d[r] = val_q[r];
      ren_d[r] = ren_q[r];
      tag_d[r] = tag_q[r];
    end
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < NCOMMIT; k++) begin
        if (c_valid[k] && c_idx[k] == RIDX_W'(r)) begin
          val_d[r] = c_val[k];
          // Only the producer currently named in the map may release it.
          if (c_tag[k] == tag_q[r]) begin
            ren_d[r] = 1'b0;
            tag_d[r] = '0;
          end
        end
      end
      if (rf.rd_valid && rf.rd_index == RIDX_W'(r)) begin
        ren_d[r] = 1'b1;
        tag_d[r] = rf.rd_tag;
      end
      if (rf.flush) begin
        ren_d[r] = 1'b0;
        tag_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      ren_q <= '0;
    end else if (rf.rdy) begin
      val_q <= val_d;
      ren_q <= ren_d;
      tag_q <= tag_d;
    end
  end
endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file with two commit channels; a monitor
// checks read ports against a queue of hand-computed expectations.
module tb_rename_reg_file;
  localparam int XLEN    = 32;
  localparam int NREG    = 32;
  localparam int ROB_W   = 4;
  localparam int NCOMMIT = 2;
  localparam int RIDX_W  = $clog2(NREG);
  localparam int EW      = 2 * (XLEN + 1 + ROB_W);

  logic clk;
  logic rst;
  logic probe;
  int   n_checks;
  int   n_fail;
  logic [EW-1:0] exp_q[$];

  rename_reg_file_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NCOMMIT(NCOMMIT)) bif ();

  rename_reg_file #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NCOMMIT(NCOMMIT)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (bif)
  );

  // Clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bif.rdy          = 1'b1;
    bif.rs1_index    = '0;
    bif.rs2_index    = '0;
    bif.need_rs1     = 1'b0;
    bif.need_rs2     = 1'b0;
    bif.rd_valid     = 1'b0;
    bif.rd_index     = '0;
    bif.rd_tag       = '0;
    bif.commit_valid = '0;
    bif.commit_index = '0;
    bif.commit_tag   = '0;
    bif.commit_value = '0;
    bif.flush        = 1'b0;
    probe            = 1'b0;
  endtask

  task automatic issue(input int idx, input int tag);
    bif.rd_valid = 1'b1;
    bif.rd_index = RIDX_W'(idx);
    bif.rd_tag   = ROB_W'(tag);
  endtask

  task automatic commit(input int k, input int idx, input int tag, input logic [XLEN-1:0] val);
    bif.commit_valid[k]                   = 1'b1;
    bif.commit_index[k*RIDX_W +: RIDX_W] = RIDX_W'(idx);
    bif.commit_tag[k*ROB_W +: ROB_W]     = ROB_W'(tag);
    bif.commit_value[k*XLEN +: XLEN]     = val;
  endtask

  task automatic chk(input int i1, input logic [XLEN-1:0] v1, input logic r1, input int t1,
                     input int i2, input logic [XLEN-1:0] v2, input logic r2, input int t2);
    bif.need_rs1  = 1'b1;
    bif.need_rs2  = 1'b1;
    bif.rs1_index = RIDX_W'(i1);
    bif.rs2_index = RIDX_W'(i2);
    exp_q.push_back({v1, r1, ROB_W'(t1), v2, r2, ROB_W'(t2)});
    probe = 1'b1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (probe) begin
      logic [EW-1:0] act;
      logic [EW-1:0] exp;
      act = {bif.rs1_value, bif.rs1_renamed, bif.rs1_tag,
             bif.rs2_value, bif.rs2_renamed, bif.rs2_tag};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL read@%0t: no expectation queued, got %h", $time, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL read@%0t rs1=%0d rs2=%0d: got v1=%h r1=%b t1=%0d v2=%h r2=%b t2=%0d, want v1=%h r1=%b t1=%0d v2=%h r2=%b t2=%0d",
                   $time, bif.rs1_index, bif.rs2_index,
                   act[EW-1 -: XLEN], act[EW/2+ROB_W], act[EW/2 +: ROB_W],
                   act[EW/2-1 -: XLEN], act[ROB_W], act[ROB_W-1:0],
                   exp[EW-1 -: XLEN], exp[EW/2+ROB_W], exp[EW/2 +: ROB_W],
                   exp[EW/2-1 -: XLEN], exp[ROB_W], exp[ROB_W-1:0]);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state
    clr(); chk(5, 0, 0, 0, 0, 0, 0, 0); step();

    // Rename, then same-cycle commit bypass
    clr(); issue(3, 2); step();
    clr(); chk(3, 0, 1, 2, 0, 0, 0, 0); step();
    clr(); commit(0, 3, 2, 32'hDEADBEEF); chk(3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0); step();
    clr(); chk(3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0); step();

    // Older commit must not release a younger rename
    clr(); issue(4, 1); step();
    clr(); issue(4, 5); step();
    clr(); commit(0, 4, 1, 32'd7); chk(4, 0, 1, 5, 3, 32'hDEADBEEF, 0, 0); step();
    clr(); chk(4, 32'd7, 1, 5, 0, 0, 0, 0); step();
    clr(); commit(0, 4, 5, 32'd9); step();
    clr(); chk(4, 32'd9, 0, 0, 0, 0, 0, 0); step();

    // Issue overrides same-cycle release; read sees the pre-issue mapping
    clr(); issue(6, 3); step();
    clr(); commit(0, 6, 3, 32'h66); issue(6, 8); chk(6, 32'h66, 0, 0, 0, 0, 0, 0); step();
    clr(); chk(6, 32'h66, 1, 8, 4, 32'd9, 0, 0); step();

    // x0 stays zero and never renamed
    clr(); issue(0, 1); commit(0, 0, 0, 32'h55); chk(0, 0, 0, 0, 0, 0, 0, 0); step();
    clr(); chk(0, 0, 0, 0, 0, 0, 0, 0); step();

    // need_rs1=0 hides the rename but still drives the value
    clr(); chk(6, 32'h66, 0, 0, 6, 32'h66, 1, 8); bif.need_rs1 = 1'b0; step();

    // Two channels on one register: younger channel wins
    clr(); issue(7, 1); step();
    clr(); issue(7, 2); step();
    clr(); commit(0, 7, 1, 32'd1); commit(1, 7, 2, 32'd2); chk(7, 32'd2, 0, 0, 0, 0, 0, 0); step();
    clr(); chk(7, 32'd2, 0, 0, 0, 0, 0, 0); step();
    clr(); issue(10, 4); step();
    clr(); commit(0, 10, 4, 32'hA); commit(1, 10, 4, 32'hB); chk(10, 32'hB, 0, 0, 0, 0, 0, 0); step();
    clr(); chk(10, 32'hB, 0, 0, 7, 32'd2, 0, 0); step();

    // Flush: frozen when rdy=0, clears renames when rdy=1
    clr(); commit(0, 8, 0, 32'h88); commit(1, 9, 0, 32'h99); step();
    clr(); issue(8, 3); step();
    clr(); issue(9, 4); step();
    clr(); chk(8, 32'h88, 1, 3, 9, 32'h99, 1, 4); step();
    clr(); bif.rdy = 1'b0; bif.flush = 1'b1; step();
    clr(); chk(8, 32'h88, 1, 3, 9, 32'h99, 1, 4); step();
    clr(); bif.flush = 1'b1; issue(8, 7); commit(0, 13, 0, 32'h13); step();
    clr(); chk(8, 32'h88, 0, 0, 9, 32'h99, 0, 0); step();
    clr(); chk(13, 32'h13, 0, 0, 0, 0, 0, 0); step();

    // rdy=0 blocks commit writes
    clr(); bif.rdy = 1'b0; commit(0, 11, 0, 32'd5); step();
    clr(); chk(11, 0, 0, 0, 0, 0, 0, 0); step();

    // Mid-operation reset wins over rdy=0 and drops renames and values
    clr(); issue(12, 6); step();
    clr(); rst = 1'b1; bif.rdy = 1'b0; step();
    rst = 1'b0;
    clr(); chk(12, 0, 0, 0, 7, 0, 0, 0); step();

    clr(); step();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
